// File: rtl/mono_data_tx_if.sv
// Hit push, readout handshake and status bundle of the MONOPIX readout emulator.
// The master side is the pattern source and receiver; the slave side is the emulated chip.
interface mono_data_tx_if #(
  parameter int DATA_WIDTH = 27
);
  logic                  HIT_WRITE;
  logic [DATA_WIDTH-1:0] HIT_DATA;
  logic                  HIT_FULL;
  logic                  FREEZE;
  logic                  READ;
  logic                  TOKEN;
  logic                  DATA;
  logic [7:0]            LOST_CNT;
  logic                  PROTO_ERR;
  logic                  ERR_CLR;

  modport master (
    output HIT_WRITE, HIT_DATA, FREEZE, READ, ERR_CLR,
    input  HIT_FULL, TOKEN, DATA, LOST_CNT, PROTO_ERR
  );

  modport slave (
    input  HIT_WRITE, HIT_DATA, FREEZE, READ, ERR_CLR,
    output HIT_FULL, TOKEN, DATA, LOST_CNT, PROTO_ERR
  );
endinterface

// File: rtl/mono_data_tx.sv
// Chip-side MONOPIX serial hit readout emulator: buffers hit words in a FIFO and
// shifts one word out MSB-first for every FREEZE/READ request from the receiver.
module mono_data_tx #(
  parameter int DATA_WIDTH   = 27,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic           CLK,
  input  logic           nRST,
  mono_data_tx_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            lat_q, lat_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic                  data_q, data_d;
  logic                  token_q, token_d;
  logic                  full_q, full_d;
  logic [7:0]            lost_q, lost_d;
  logic                  proto_q, proto_d;
  logic                  read_q;

  logic fifo_empty, fifo_full, push, drop, pop, read_rise, proto_evt;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = bus.HIT_WRITE & ~fifo_full & ~bus.FREEZE;
  assign drop       = bus.HIT_WRITE & ~push;
  assign read_rise  = bus.READ & ~read_q;

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.HIT_DATA;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    lat_d     = lat_q;
    bit_d     = bit_q;
    data_d    = 1'b0;
    pop       = 1'b0;
    proto_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_rise) begin
          if (bus.FREEZE && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q[AW-1:0]];
            lat_d   = 3'(READ_LATENCY - 1);
            state_d = ST_WAIT;
          end else begin
            proto_evt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        proto_evt = read_rise;
        if (lat_q == 3'd0) begin
          // First bit is registered on the same edge that enters SHIFT.
          state_d = ST_SHIFT;
          data_d  = shift_q[DATA_WIDTH-1];
          shift_d = shift_q << 1;
          bit_d   = '0;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_SHIFT: begin
        proto_evt = read_rise;
        if (bit_q == CW'(DATA_WIDTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = shift_q[DATA_WIDTH-1];
          shift_d = shift_q << 1;
          bit_d   = bit_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    token_d  = ~fifo_empty | (state_q != ST_IDLE);

    lost_d = lost_q;
    if (bus.ERR_CLR) begin
      lost_d = drop ? 8'd1 : 8'd0;
    end else if (drop && lost_q != 8'hFF) begin
      lost_d = lost_q + 8'd1;
    end
    // A fresh error in the clearing cycle survives the clear.
    proto_d = bus.ERR_CLR ? proto_evt : (proto_q | proto_evt);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      shift_q  <= '0;
      lat_q    <= '0;
      bit_q    <= '0;
      data_q   <= 1'b0;
      token_q  <= 1'b0;
      full_q   <= 1'b0;
      lost_q   <= '0;
      proto_q  <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      shift_q  <= shift_d;
      lat_q    <= lat_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      token_q  <= token_d;
      full_q   <= full_d;
      lost_q   <= lost_d;
      proto_q  <= proto_d;
      read_q   <= bus.READ;
    end
  end

  assign bus.HIT_FULL  = full_q;
  assign bus.TOKEN     = token_q;
  assign bus.DATA      = data_q;
  assign bus.LOST_CNT  = lost_q;
  assign bus.PROTO_ERR = proto_q;
endmodule

// File: tb/tb_mono_data_tx.sv
// Directed bench for mono_data_tx: push table, serial readback, error paths,
// saturation and asynchronous reset in the middle of a word.
module tb_mono_data_tx;
  localparam int W   = 27;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mono_data_tx_if #(.DATA_WIDTH(W)) bus ();

  mono_data_tx #(.DATA_WIDTH(W), .DEPTH(16), .READ_LATENCY(LAT)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         exp_full;
    logic [7:0]   exp_lost;
  } push_vec_t;

  push_vec_t pv [17];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    bus.FREEZE    = 1'b0;
    bus.HIT_WRITE = 1'b1;
    bus.HIT_DATA  = w;
    tick();
    bus.HIT_WRITE = 1'b0;
  endtask

  // Issues one READ pulse and collects the word; returns one cycle after the last bit.
  task automatic read_word(output logic [W-1:0] w);
    w = '0;
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    repeat (LAT - 1) tick();
    check("data_wait", 32'(bus.DATA), 32'd0);
    for (int i = 0; i < W; i++) begin
      tick();
      w = {w[W-2:0], bus.DATA};
    end
    tick();
    check("data_idle", 32'(bus.DATA), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;

    for (int i = 0; i < 17; i++) begin
      pv[i].word     = W'(32'h0246_8ACE + i * 32'h0135_79BD);
      pv[i].exp_full = (i >= 15);
      pv[i].exp_lost = (i == 16) ? 8'd1 : 8'd0;
    end

    bus.HIT_WRITE = 1'b0;
    bus.HIT_DATA  = '0;
    bus.FREEZE    = 1'b0;
    bus.READ      = 1'b0;
    bus.ERR_CLR   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_token", 32'(bus.TOKEN), 32'd0);
    check("rst_data", 32'(bus.DATA), 32'd0);
    check("rst_full", 32'(bus.HIT_FULL), 32'd0);
    check("rst_lost", 32'(bus.LOST_CNT), 32'd0);
    check("rst_proto", 32'(bus.PROTO_ERR), 32'd0);
    #3 nrst = 1'b1;
    tick();

    // Single word, TOKEN latency and MSB-first serialisation
    push(W'(32'h05A5A5A5));
    check("tok_lat1", 32'(bus.TOKEN), 32'd0);
    tick();
    check("tok_lat2", 32'(bus.TOKEN), 32'd1);
    bus.FREEZE = 1'b1;
    tick();
    read_word(w);
    check("word_5a5", 32'(w), 32'b101_1010_0101_1010_0101_1010_0101);
    check("tok_hold", 32'(bus.TOKEN), 32'd1);
    tick();
    check("tok_clr", 32'(bus.TOKEN), 32'd0);
    check("data_after", 32'(bus.DATA), 32'd0);

    // Three words read in FIFO order with one idle cycle between them
    push(W'(32'h0000_0001));
    push(W'(32'h0400_0000));
    push(W'(32'h0333_3333));
    bus.FREEZE = 1'b1;
    tick();
    read_word(w);
    check("w3_0", 32'(w), 32'h0000_0001);
    check("w3_tok0", 32'(bus.TOKEN), 32'd1);
    read_word(w);
    check("w3_1", 32'(w), 32'h0400_0000);
    check("w3_tok1", 32'(bus.TOKEN), 32'd1);
    read_word(w);
    check("w3_2", 32'(w), 32'h0333_3333);
    check("w3_tok2", 32'(bus.TOKEN), 32'd1);
    tick();
    check("w3_tok_end", 32'(bus.TOKEN), 32'd0);
    check("w3_proto", 32'(bus.PROTO_ERR), 32'd0);

    // Fill past DEPTH from the table, then read everything back
    for (int i = 0; i < 17; i++) begin
      push(pv[i].word);
      check($sformatf("fill_full_%0d", i), 32'(bus.HIT_FULL), 32'(pv[i].exp_full));
      check($sformatf("fill_lost_%0d", i), 32'(bus.LOST_CNT), 32'(pv[i].exp_lost));
    end
    bus.FREEZE = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      read_word(w);
      check($sformatf("fill_rd_%0d", i), 32'(w), 32'(pv[i].word));
      if (i == 0) check("full_clr", 32'(bus.HIT_FULL), 32'd0);
    end
    tick();
    check("fill_tok_end", 32'(bus.TOKEN), 32'd0);

    // Drop while frozen, read while empty, error clear
    bus.HIT_WRITE = 1'b1;
    tick();
    bus.HIT_WRITE = 1'b0;
    check("frz_lost", 32'(bus.LOST_CNT), 32'd2);
    tick();
    check("frz_tok", 32'(bus.TOKEN), 32'd0);
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    check("empty_proto", 32'(bus.PROTO_ERR), 32'd1);
    tick();
    check("empty_data", 32'(bus.DATA), 32'd0);
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    check("clr_proto", 32'(bus.PROTO_ERR), 32'd0);
    check("clr_lost", 32'(bus.LOST_CNT), 32'd0);
    bus.ERR_CLR   = 1'b1;
    bus.HIT_WRITE = 1'b1;
    tick();
    bus.ERR_CLR   = 1'b0;
    bus.HIT_WRITE = 1'b0;
    check("clr_vs_drop", 32'(bus.LOST_CNT), 32'd1);

    // READ during SHIFT: word intact, error flagged, nothing extra popped
    push(W'(32'h0123_4567));
    push(W'(32'h0765_4321));
    bus.FREEZE = 1'b1;
    tick();
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    repeat (LAT - 1) tick();
    w = '0;
    for (int i = 0; i < W; i++) begin
      bus.READ = (i == 10);
      tick();
      w = {w[W-2:0], bus.DATA};
    end
    bus.READ = 1'b0;
    tick();
    check("mid_word", 32'(w), 32'h0123_4567);
    check("mid_proto", 32'(bus.PROTO_ERR), 32'd1);
    read_word(w);
    check("mid_next", 32'(w), 32'h0765_4321);
    tick();
    check("mid_tok_end", 32'(bus.TOKEN), 32'd0);

    // Saturation of the lost counter
    bus.HIT_WRITE = 1'b1;
    repeat (300) tick();
    bus.HIT_WRITE = 1'b0;
    check("lost_sat", 32'(bus.LOST_CNT), 32'd255);

    // Asynchronous reset in the middle of an all-ones word
    push(W'(32'h07FF_FFFF));
    bus.FREEZE = 1'b1;
    tick();
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    repeat (LAT - 1 + 5) tick();
    check("pre_rst_data", 32'(bus.DATA), 32'd1);
    #3 nrst = 1'b0;
    #1;
    check("arst_data", 32'(bus.DATA), 32'd0);
    check("arst_token", 32'(bus.TOKEN), 32'd0);
    check("arst_full", 32'(bus.HIT_FULL), 32'd0);
    check("arst_lost", 32'(bus.LOST_CNT), 32'd0);
    check("arst_proto", 32'(bus.PROTO_ERR), 32'd0);
    #2 nrst = 1'b1;
    bus.FREEZE = 1'b0;
    repeat (2) tick();
    check("post_rst_tok", 32'(bus.TOKEN), 32'd0);
    push(W'(32'h0555_AAAA));
    bus.FREEZE = 1'b1;
    tick();
    check("post_rst_tok1", 32'(bus.TOKEN), 32'd1);
    read_word(w);
    check("post_rst_word", 32'(w), 32'h0555_AAAA);
    tick();
    check("post_rst_tok0", 32'(bus.TOKEN), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mono_data_tx.md
Name: mono_data_tx

Overview:
- Chip-side emulator of the MONOPIX serial hit readout. It is the transmitter counterpart of the mono_data_rx receiver.
- Hit words are pushed in from a pattern source and buffered in an internal FIFO.
- The block raises TOKEN while hits are pending. It answers the receiver's FREEZE/READ sequence by shifting one hit word out MSB-first on DATA.
- It is used in firmware loopback test mode and in the simulation bench, where it stands in for the chip.

Parameters:
- DATA_WIDTH, 27, bits per hit word: {col[5:0], row[8:0], te[5:0], le[5:0]}.
- DEPTH, 16, internal hit FIFO depth in words; must be a power of 2 and at least 2.
- READ_LATENCY, 2, CLK cycles from the READ rising edge to the first DATA bit; range 1..7.

Ports:
- CLK  input  1  single clock: readout bit clock and all internal logic.
- nRST  input  1  asynchronous active-low reset.
- HIT_WRITE  input  1  push strobe for one hit word.
- HIT_DATA  input  DATA_WIDTH  hit word, sampled while HIT_WRITE=1.
- HIT_FULL  output  1  FIFO full.
- FREEZE  input  1  driven by the receiver; freezes the hit set being read out.
- READ  input  1  driven by the receiver; a rising edge requests one word.
- TOKEN  output  1  hits pending.
- DATA  output  1  serial data, MSB first.
- LOST_CNT  output  8  count of dropped pushes; saturates at 255.
- PROTO_ERR  output  1  sticky protocol-violation flag.
- ERR_CLR  input  1  clears PROTO_ERR and LOST_CNT.

Behaviour:
Reset (nRST=0, asynchronous):
- FIFO emptied; state IDLE.
- TOKEN=0, DATA=0, HIT_FULL=0, LOST_CNT=0, PROTO_ERR=0.
- READ edge-detect register cleared to 0.

All logic is clocked on posedge CLK. Every output is registered.

Push path:
- A push is accepted when HIT_WRITE=1 and FIFO not full and FREEZE=0.
- HIT_WRITE=1 while full or while FREEZE=1: word dropped, LOST_CNT+1 (saturating).
- Push and pop in the same cycle are both honoured. Occupancy is unchanged, and the pop side sees the word at the head before this push.
- HIT_FULL is registered and reflects occupancy after this cycle's push/pop.

TOKEN:
- Registered.
- TOKEN=1 when FIFO occupancy > 0, or when state is WAIT or SHIFT.
- Otherwise TOKEN=0, updated the cycle after the condition changes.

READ edge:
- read_rise = READ & ~READ_d, where READ_d is READ delayed by 1 CLK.

State machine:
- IDLE, DATA=0.
  - read_rise with FREEZE=1 and FIFO not empty: pop the head word into the shift register, load the latency counter with READ_LATENCY-1, go to WAIT.
  - read_rise with FREEZE=0, or with FIFO empty: set PROTO_ERR, stay in IDLE.
- WAIT, DATA=0.
  - Counter decrements each cycle.
  - When the counter is 0, go to SHIFT.
  - For READ_LATENCY=1, WAIT lasts 1 cycle.
  - First DATA bit appears on the output exactly READ_LATENCY cycles after the cycle in which read_rise is seen.
- SHIFT.
  - DATA = shift register MSB; shift left by one each cycle for exactly DATA_WIDTH cycles.
  - Bit counter counts 0..DATA_WIDTH-1.
  - After the last bit, go to IDLE; DATA returns to 0 the next cycle.
  - Back-to-back READs are served from IDLE, giving a minimum of one idle DATA=0 cycle between words.
- read_rise during WAIT or SHIFT: ignored for data, PROTO_ERR set.
- FREEZE falling during WAIT or SHIFT: the current word completes unaltered; no error.

Last word:
- The TOKEN register clears on the cycle after SHIFT ends when the FIFO is empty.
- A receiver sampling TOKEN after the last bit therefore sees 0.

ERR_CLR:
- Synchronous; clears LOST_CNT and PROTO_ERR.
- An error event in the same cycle as ERR_CLR wins: the flag is set, and the counter becomes 1.

Width rules:
- FIFO pointers are log2(DEPTH)+1 bits; wrap naturally.
- Full when the MSBs differ and the rest are equal; empty when all bits are equal.

Test Plan:
- Reset, push 27'h5A5A5A5 with FREEZE=0 → TOKEN=1 two cycles after the push. Then FREEZE=1 and a 1-cycle READ → DATA shows 27 bits MSB-first starting 2 cycles after the READ edge: 101_1010_0101_1010_0101_1010_0101. After that, TOKEN=0 and DATA=0.
- Push 3 words, FREEZE=1, three READ pulses each issued after the previous word finishes → 3 words in FIFO order. TOKEN stays 1 until the cycle after the third word's last bit, then 0. PROTO_ERR=0.
- Push 17 words into DEPTH=16 → HIT_FULL=1 after the 16th push; LOST_CNT=1. Read all 16 words back correctly; FIFO ends empty.
- Assert HIT_WRITE with FREEZE=1 → LOST_CNT increments and TOKEN is unchanged. Issue READ with FIFO empty → PROTO_ERR=1, DATA stays 0. Pulse ERR_CLR → PROTO_ERR=0 and LOST_CNT=0.
- Issue READ mid-SHIFT → current word is output bit-exact, PROTO_ERR=1, no extra word popped. Drive 300 dropped pushes → LOST_CNT=255.
- Assert nRST=0 mid-SHIFT (asynchronous, not clock-aligned) → DATA=0, TOKEN=0, HIT_FULL=0 immediately. After release, the FIFO is empty and a new push/read cycle works.
